// File: rtl/traffic_pkg.sv
// Shared encodings and the round-robin phase search for the N-phase signal controller.
package traffic_pkg;

  localparam logic [1:0] LIGHT_FAIL   = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_RED    = 2'b11;

  typedef enum logic [3:0] {
    ST_FS     = 4'b0001,
    ST_ALLRED = 4'b0010,
    ST_GRN    = 4'b0100,
    ST_YEL    = 4'b1000
  } state_e;

  // Returns {found, index}: first set demand bit scanning from cur+1, wrapping, cur itself last.
  function automatic logic [3:0] rr_select(logic [7:0] dem, logic [2:0] cur, int unsigned n);
    logic [3:0] sel;
    int unsigned idx;
    sel = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      if (k <= n) begin
        idx = (32'(cur) + k) % n;
        if (!sel[3] && dem[idx[2:0]]) sel = {1'b1, idx[2:0]};
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable saturating down-counter; timeup is high while the count sits at zero.
module phase_timer #(
  parameter int            TW          = 8,
  parameter logic [TW-1:0] RESET_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  output logic          timeup
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) count_d = load_value;
    else if (count_q != '0) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= RESET_VALUE;
    else        count_q <= count_d;
  end

  assign timeup = (count_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase signal controller: latched demand, round-robin service, min/max green,
// rest-in-green / rest-in-red, and a fault-driven fail-safe state.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES  = 3,
  parameter int TW          = 8,
  parameter int FS_TIME     = 4,
  parameter int ALLRED_TIME = 2,
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 12,
  parameter int YELLOW_TIME = 3
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic [NUM_PHASES-1:0]         Sensor,
  input  logic                          Fault,
  output logic [2*NUM_PHASES-1:0]       Lights,
  output logic [$clog2(NUM_PHASES)-1:0] Phase,
  output logic [NUM_PHASES-1:0]         Demand,
  output logic                          InFailSafe
);

  localparam int PW = $clog2(NUM_PHASES);

  state_e                  state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [NUM_PHASES-1:0]   demand_q, demand_d;
  logic [TW-1:0]           green_q, green_d;
  logic [2*NUM_PHASES-1:0] lights_q, lights_d;

  logic                    tmr_load;
  logic [TW-1:0]           tmr_value;
  logic                    timeup;
  logic                    enter_grn;
  logic [7:0]              dem_ext;
  logic [2:0]              cur_ext;
  logic [3:0]              sel;
  logic [NUM_PHASES-1:0]   phase_onehot;
  logic                    other_demand;

  phase_timer #(
    .TW          (TW),
    .RESET_VALUE (TW'(FS_TIME - 1))
  ) u_timer (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .timeup     (timeup)
  );

  always_comb begin
    dem_ext                 = '0;
    dem_ext[NUM_PHASES-1:0] = demand_q;
    cur_ext                 = '0;
    cur_ext[PW-1:0]         = phase_q;
  end

  assign sel          = rr_select(dem_ext, cur_ext, NUM_PHASES);
  assign phase_onehot = NUM_PHASES'(1) << phase_q;
  assign other_demand = |(demand_q & ~phase_onehot);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    green_d   = green_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    enter_grn = 1'b0;
    if (Fault) begin
      // Holding the load keeps the fail-safe dwell full length once Fault drops.
      state_d   = ST_FS;
      tmr_load  = 1'b1;
      tmr_value = TW'(FS_TIME - 1);
    end else begin
      case (state_q)
        ST_FS: begin
          if (timeup) begin
            state_d   = ST_ALLRED;
            tmr_load  = 1'b1;
            tmr_value = TW'(ALLRED_TIME - 1);
          end
        end
        ST_ALLRED: begin
          if (timeup && sel[3]) begin
            state_d   = ST_GRN;
            phase_d   = PW'(sel[2:0]);
            green_d   = TW'(1);
            enter_grn = 1'b1;
          end
        end
        ST_GRN: begin
          if (green_q != '1) green_d = green_q + 1'b1;
          if (other_demand &&
              ((green_q >= TW'(MIN_GREEN) && !Sensor[phase_q]) || green_q >= TW'(MAX_GREEN))) begin
            state_d   = ST_YEL;
            tmr_load  = 1'b1;
            tmr_value = TW'(YELLOW_TIME - 1);
          end
        end
        ST_YEL: begin
          if (timeup) begin
            state_d   = ST_ALLRED;
            tmr_load  = 1'b1;
            tmr_value = TW'(ALLRED_TIME - 1);
          end
        end
        default: begin
          state_d   = ST_FS;
          tmr_load  = 1'b1;
          tmr_value = TW'(FS_TIME - 1);
        end
      endcase
    end
  end

  // The served phase cannot re-request itself while green; entering green clears its bit.
  always_comb begin
    demand_d = demand_q | (Sensor & ~((state_q == ST_GRN) ? phase_onehot : '0));
    if (enter_grn) demand_d = demand_d & ~(NUM_PHASES'(1) << phase_d);
  end

  always_comb begin
    lights_d = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      case (state_d)
        ST_ALLRED: lights_d[2*i +: 2] = LIGHT_RED;
        ST_GRN:    lights_d[2*i +: 2] = (PW'(i) == phase_d) ? LIGHT_GREEN : LIGHT_RED;
        ST_YEL:    lights_d[2*i +: 2] = (PW'(i) == phase_d) ? LIGHT_YELLOW : LIGHT_RED;
        default:   lights_d[2*i +: 2] = LIGHT_FAIL;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_FS;
      phase_q  <= PW'(NUM_PHASES - 1);
      demand_q <= '0;
      green_q  <= '0;
      lights_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      demand_q <= demand_d;
      green_q  <= green_d;
      lights_q <= lights_d;
    end
  end

  assign Lights     = lights_q;
  assign Phase      = phase_q;
  assign Demand     = demand_q;
  assign InFailSafe = (state_q == ST_FS);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with default parameters (3 phases).
module tb_traffic_phase_ctrl;

  localparam int K_FS = 0, K_AR = 1, K_G = 2, K_Y = 3;

  logic       Clock, Reset_n, Fault, InFailSafe;
  logic [2:0] Sensor, Demand;
  logic [5:0] Lights;
  logic [1:0] Phase;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  traffic_phase_ctrl #(
    .NUM_PHASES(3), .TW(8), .FS_TIME(4), .ALLRED_TIME(2),
    .MIN_GREEN(5), .MAX_GREEN(12), .YELLOW_TIME(3)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Sensor     (Sensor),
    .Fault      (Fault),
    .Lights     (Lights),
    .Phase      (Phase),
    .Demand     (Demand),
    .InFailSafe (InFailSafe)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [5:0] lamps(int kind, int ph);
    logic [5:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      if (kind == K_AR)      v[2*i +: 2] = 2'b11;
      else if (kind == K_G)  v[2*i +: 2] = (i == ph) ? 2'b01 : 2'b11;
      else if (kind == K_Y)  v[2*i +: 2] = (i == ph) ? 2'b10 : 2'b11;
    end
    return v;
  endfunction

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lamps(string tag, int kind, int ph);
    chk({tag, ".lights"}, 8'(Lights), 8'(lamps(kind, ph)));
    chk({tag, ".infs"}, 8'(InFailSafe), 8'(kind == K_FS));
  endtask

  // Starts on the first GRN cycle of ph; ends on the first GRN cycle of the next phase.
  task automatic serve(string tag, int ph, int len);
    chk_lamps({tag, ".entry"}, K_G, ph);
    chk({tag, ".phase"}, 8'(Phase), 8'(ph));
    step(len - 1);
    chk_lamps({tag, ".last_green"}, K_G, ph);
    step(1);
    chk_lamps({tag, ".yellow"}, K_Y, ph);
    step(3);
    chk_lamps({tag, ".allred"}, K_AR, 0);
    step(2);
  endtask

  initial begin
    Reset_n = 1'b0;
    Sensor  = 3'b000;
    Fault   = 1'b0;

    // Reset values, then fail-safe dwell and rest in red
    #12;
    chk_lamps("reset", K_FS, 0);
    chk("reset.demand", 8'(Demand), 8'h0);
    chk("reset.phase", 8'(Phase), 8'd2);
    Reset_n = 1'b1;
    step(3);
    chk_lamps("fs.cycle3", K_FS, 0);
    step(1);
    chk_lamps("fs.exit", K_AR, 0);
    step(5);
    chk_lamps("rest_red", K_AR, 0);
    chk("rest_red.demand", 8'(Demand), 8'h0);

    // One-cycle sensor pulse on phase 1, then rest in green
    Sensor = 3'b010;
    step(1);
    Sensor = 3'b000;
    chk("latch.demand", 8'(Demand), 8'b010);
    chk_lamps("latch.still_red", K_AR, 0);
    step(1);
    chk_lamps("grn1", K_G, 1);
    chk("grn1.phase", 8'(Phase), 8'd1);
    chk("grn1.demand", 8'(Demand), 8'b000);
    step(20);
    chk_lamps("rest_green", K_G, 1);

    // Gap-out to phase 0, then max-out while Sensor[0] stays high
    Sensor = 3'b001;
    step(1);
    Sensor = 3'b000;
    chk("p0req.demand", 8'(Demand), 8'b001);
    step(1);
    chk_lamps("gapout1.yel", K_Y, 1);
    step(3);
    chk_lamps("gapout1.allred", K_AR, 0);
    step(2);
    chk_lamps("grn0", K_G, 0);
    chk("grn0.phase", 8'(Phase), 8'd0);
    Sensor = 3'b001;
    step(1);
    Sensor = 3'b101;
    step(1);
    Sensor = 3'b001;
    step(9);
    chk_lamps("maxout.g12", K_G, 0);
    chk("maxout.demand", 8'(Demand), 8'b100);
    step(1);
    chk_lamps("maxout.yel", K_Y, 0);
    step(1);
    Sensor = 3'b000;
    chk("maxout.yel_demand", 8'(Demand), 8'b101);
    chk_lamps("maxout.yel2", K_Y, 0);
    step(2);
    chk_lamps("maxout.allred", K_AR, 0);
    step(2);
    chk_lamps("grn2", K_G, 2);
    chk("grn2.phase", 8'(Phase), 8'd2);
    chk("grn2.demand", 8'(Demand), 8'b001);

    // Round-robin service with all phases requesting
    serve("rr.p2a", 2, 5);
    chk("rr.p0.demand0", 8'(Demand), 8'b000);
    chk_lamps("rr.p0", K_G, 0);
    Sensor = 3'b111;
    step(1);
    Sensor = 3'b000;
    chk("rr.p0.demand", 8'(Demand), 8'b110);
    step(3);
    chk_lamps("rr.p0.g5", K_G, 0);
    step(1);
    chk_lamps("rr.p0.yel", K_Y, 0);
    Sensor = 3'b001;
    step(1);
    Sensor = 3'b000;
    chk("rr.all_demand", 8'(Demand), 8'b111);
    step(4);
    chk("rr.p1.demand", 8'(Demand), 8'b101);
    serve("rr.p1", 1, 5);
    chk("rr.p2.demand", 8'(Demand), 8'b001);
    serve("rr.p2b", 2, 5);
    chk("rr.p0b.demand", 8'(Demand), 8'b000);
    chk_lamps("rr.p0b", K_G, 0);
    step(15);
    chk_lamps("rr.p0b.rest", K_G, 0);

    // Fault in yellow: fail-safe held, full dwell after release, demand kept
    Sensor = 3'b010;
    step(1);
    Sensor = 3'b000;
    step(1);
    chk_lamps("fault.yel", K_Y, 0);
    step(1);
    Fault = 1'b1;
    step(1);
    chk_lamps("fault.fs", K_FS, 0);
    step(5);
    chk_lamps("fault.held", K_FS, 0);
    chk("fault.demand", 8'(Demand), 8'b010);
    Fault = 1'b0;
    step(3);
    chk_lamps("fault.dwell3", K_FS, 0);
    step(1);
    chk_lamps("fault.allred", K_AR, 0);
    chk("fault.allred_demand", 8'(Demand), 8'b010);
    step(2);
    chk_lamps("fault.grn1", K_G, 1);
    chk("fault.grn1_phase", 8'(Phase), 8'd1);

    // Asynchronous reset in the middle of green
    Sensor = 3'b001;
    step(1);
    Sensor = 3'b000;
    chk("areset.pre_demand", 8'(Demand), 8'b001);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_lamps("areset", K_FS, 0);
    chk("areset.demand", 8'(Demand), 8'h0);
    chk("areset.phase", 8'(Phase), 8'd2);
    #4;
    Reset_n = 1'b1;
    step(4);
    chk_lamps("areset.allred", K_AR, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Parametrised N-phase traffic signal controller; successor to the fixed three-light, two-phase intersection controller.
- Each phase has one vehicle sensor and one 2-bit light output. Exactly one phase is green or yellow at a time; all other phases are red.
- Adds latched demand, round-robin service, a min/max green window, rest-in-green, rest-in-red, an external fault input, and one shared interval timer.
- Sits between the sensor conditioning logic and the lamp drivers.

Parameters:
- NUM_PHASES, 3, number of signal phases (2..8).
- TW, 8, timer width in bits; every *_TIME value must be in 1..2^TW-1.
- FS_TIME, 4, fail-safe dwell in cycles after reset or after Fault drops.
- ALLRED_TIME, 2, all-red clearance interval in cycles.
- MIN_GREEN, 5, guaranteed green cycles.
- MAX_GREEN, 12, total green cycles allowed when there is conflicting demand (must be >= MIN_GREEN).
- YELLOW_TIME, 3, yellow interval in cycles.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Sensor  in  NUM_PHASES  bit i = vehicle present on phase i (synchronous, level).
- Fault  in  1  synchronous fault request; forces fail-safe.
- Lights  out  2*NUM_PHASES  bits [2i+1:2i] = light of phase i; FAIL=00, GREEN=01, YELLOW=10, RED=11.
- Phase  out  clog2(NUM_PHASES)  index of the phase currently or most recently served.
- Demand  out  NUM_PHASES  latched demand register (observability).
- InFailSafe  out  1  high while in FS.

Behaviour:
- Reset (asynchronous, Reset_n=0): state=FS, Lights=all 00, Phase=NUM_PHASES-1, Demand=0, InFailSafe=1, timer loaded with FS_TIME-1. Asserting reset mid-operation has the same effect at any time.
- States: FS, ALLRED, GRN, YEL. Registered Moore outputs, decoded from state and Phase.
  - FS: all 00.
  - ALLRED: all 11.
  - GRN: Phase=01, all others 11.
  - YEL: Phase=10, all others 11.
- Timer:
  - On entry to a state, the timer loads that state's interval minus 1.
  - It decrements every cycle and saturates at 0. timeup = (timer==0).
  - Result: a state with interval T lasts exactly T cycles when exit is gated only by timeup.
- Demand register:
  - Demand[i] sets when Sensor[i]=1, except for the served phase while in GRN.
  - Demand[Phase] clears on the cycle GRN is entered.
  - If set and clear hit the same bit in the same cycle, clear wins.
  - Demand is not cleared by FS; only reset clears it fully.
- Next-phase select: round-robin search starting at Phase+1 (mod NUM_PHASES) for the first set Demand bit. "Other demand" = any Demand bit other than Phase.
- FS -> ALLRED: when timeup and Fault=0. While Fault=1, the timer is held at FS_TIME-1.
- ALLRED:
  - timeup and a selected phase exists -> GRN; Phase <= selected index.
  - timeup and no demand -> stay ALLRED (rest in red), timer held at 0.
- GRN:
  - Green count g = cycles spent in GRN so far, counted from 1 on the entry cycle.
  - Exit to YEL at the end of cycle g when:
    - g >= MIN_GREEN, other demand exists, and Sensor[Phase]=0 (gap-out); or
    - g >= MAX_GREEN and other demand exists (max-out).
  - With no other demand, stay in GRN indefinitely (rest in green), regardless of MAX_GREEN.
  - An internal green counter of width TW saturates at its maximum.
- YEL -> ALLRED on timeup. Phase is unchanged.
- Fault=1 in any state -> FS on the next edge. Fault has highest priority over all other transitions. InFailSafe=1 in FS.
- Phase holds its value outside ALLRED->GRN transitions.
- Illegal state encoding -> FS.

Decomposition:
- Package traffic_pkg:
  - light encodings FAIL/GREEN/YELLOW/RED;
  - state encoding (one-hot, 4 bits);
  - a function for the round-robin next-phase search.
- Sub-module phase_timer:
  - TW-bit loadable saturating down-counter;
  - inputs load and load_value; output timeup.
  - The FSM instantiates one phase_timer plus a separate green-age counter.

Test Plan:
1. Reset, then release with Fault=0 and Sensor=0 → FS for 4 cycles (Lights=000000), then ALLRED resting (111111), Demand=000.
2. From rest, Sensor=3'b010 pulsed for 1 cycle → after the ALLRED timeup: Phase=1, Lights=11_01_11, Demand[1] cleared; green persists with no other demand.
3. In GRN on phase 0 with Sensor[0] held at 1 and Sensor[2] pulsed at g=2 → exit at g=12 (max-out), then YEL for 3 cycles, ALLRED for 2 cycles, then GRN on phase 2.
4. Demand=3'b111 while phase 0 is green and Sensor[0]=0 → exit at g=5; service order is 1, 2, 0; each green lasts 5 cycles.
5. Fault asserted mid-YEL → next cycle FS with Lights=0; held while Fault=1; after Fault drops, exactly 4 FS cycles, then ALLRED; pending Demand is preserved.
6. Reset_n pulsed low mid-GRN (not on a clock edge) → Lights go to 0 immediately; state=FS, Demand=0.
